// File: rtl/red_pitaya_pdm_dec.sv
// Multi-channel PDM / sigma-delta bitstream decoder.
// Each channel synchronises its 1-bit input and counts ones over a shared window of rl clocks.
// All channels deliver their counts together on dat with a single-cycle vld strobe.
// ovr is a sticky flag: it records that rng moved while a window was in flight.
module red_pitaya_pdm_dec #(
  parameter int DWC = 8,
  parameter int CHN = 4,
  parameter int SYN = 2
)(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ena,
  input  logic [DWC-1:0]           rng,
  input  logic [CHN-1:0]           pdm_i,
  output logic [CHN-1:0][DWC-1:0]  dat,
  output logic                     vld,
  output logic                     ovr
);

  localparam int FW = (SYN > 1) ? $clog2(SYN) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, WAIT, RUN} state_t;

  state_t                   state, state_nxt;
  logic [CHN-1:0][SYN-1:0]  syn;
  logic [CHN-1:0]           bits;
  logic [CHN-1:0][DWC-1:0]  acc;
  logic [DWC-1:0]           wcnt;
  logic [DWC-1:0]           rl;
  logic [FW-1:0]            fcnt;
  logic                     chg;
  logic                     flush_done;
  logic                     last;

  // Synchronise each asynchronous PDM input through SYN flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syn <= '0;
    end else begin
      for (int c = 0; c < CHN; c++) begin
        syn[c] <= {syn[c][SYN-2:0], pdm_i[c]};
      end
    end
  end

  // Pick the synchronised bit of every channel and flag the last cycle of a window
  always_comb begin
    bits = '0;
    for (int c = 0; c < CHN; c++) begin
      bits[c] = syn[c][SYN-1];
    end
    flush_done = (fcnt == FW'(SYN-1));
    last       = (state == RUN) && (wcnt == (rl - DWC'(1)));
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping ena returns to IDLE from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ena) state_nxt = FLUSH;
      FLUSH: if (flush_done) state_nxt = (rng != '0) ? RUN : WAIT;
      WAIT:  if (rng != '0) state_nxt = RUN;
      RUN:   if (last && (rng == '0)) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
    if (!ena) state_nxt = IDLE;
  end

  // Window datapath: accumulate ones, deliver counts at the window boundary, track rng changes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= '0;
      wcnt <= '0;
      rl   <= '0;
      fcnt <= '0;
      chg  <= 1'b0;
      dat  <= '0;
      vld  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (state == IDLE) begin
        acc  <= '0;
        wcnt <= '0;
        fcnt <= '0;
        chg  <= 1'b0;
        ovr  <= 1'b0;
      end else if (ena) begin
        case (state)
          FLUSH: begin
            fcnt <= fcnt + FW'(1);
            acc  <= '0;
            wcnt <= '0;
            chg  <= 1'b0;
            if (flush_done) rl <= rng;
          end
          WAIT: begin
            rl   <= rng;
            acc  <= '0;
            wcnt <= '0;
            chg  <= 1'b0;
          end
          RUN: begin
            if (last) begin
              for (int c = 0; c < CHN; c++) begin
                dat[c] <= acc[c] + DWC'(bits[c]);
              end
              acc  <= '0;
              wcnt <= '0;
              rl   <= rng;
              vld  <= 1'b1;
              chg  <= 1'b0;
              if (chg || (rng != rl)) ovr <= 1'b1;
            end else begin
              for (int c = 0; c < CHN; c++) begin
                acc[c] <= acc[c] + DWC'(bits[c]);
              end
              wcnt <= wcnt + DWC'(1);
              if (rng != rl) chg <= 1'b1;
            end
          end
          default: begin
            acc <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pdm_dec.sv
// Directed testbench for red_pitaya_pdm_dec (DWC=8, CHN=4, SYN=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_red_pitaya_pdm_dec;

  localparam int DWC = 8;
  localparam int CHN = 4;
  localparam int SYN = 2;

  logic                     clk;
  logic                     rstn;
  logic                     ena;
  logic [DWC-1:0]           rng;
  logic [CHN-1:0]           pdm_i;
  logic [CHN-1:0][DWC-1:0]  dat;
  logic                     vld;
  logic                     ovr;

  int checks;
  int failures;
  int n;
  int gacc [CHN];
  int gcfg [CHN];

  red_pitaya_pdm_dec #(.DWC(DWC), .CHN(CHN), .SYN(SYN)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .ena   (ena),
    .rng   (rng),
    .pdm_i (pdm_i),
    .dat   (dat),
    .vld   (vld),
    .ovr   (ovr)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the functional inputs
  task automatic applyStimulus(input logic e, input logic [DWC-1:0] r, input logic [CHN-1:0] p);
    ena   = e;
    rng   = r;
    pdm_i = p;
  endtask

  // One comparison: counts it and reports on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Tick until vld is seen; returns ticks taken, or maxT when the bound expires
  task automatic waitVld(input int maxT, output int cnt);
    cnt = 0;
    while (cnt < maxT) begin
      tick(1);
      cnt++;
      if (vld) break;
    end
    if (!vld) cnt = maxT;
  endtask

  // Count vld strobes over a fixed number of ticks
  task automatic countVld(input int ticks, output int cnt);
    cnt = 0;
    for (int i = 0; i < ticks; i++) begin
      tick(1);
      if (vld) cnt++;
    end
  endtask

  // Stimulus sequence
  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    applyStimulus(1'b0, 8'd0, 4'b0101);
    tick(3);

    $display("[TB] reset state");
    checkOutput("reset_dat", dat, 32'h0);
    checkOutput("reset_vld", {31'd0, vld}, 32'd0);
    checkOutput("reset_ovr", {31'd0, ovr}, 32'd0);
    rstn = 1'b1;
    tick(4);

    $display("[TB] constant inputs rng=10 pdm=0101");
    applyStimulus(1'b1, 8'd10, 4'b0101);
    waitVld(40, n);
    checkOutput("const_first_vld_latency", n, SYN + 11);
    checkOutput("const_dat_first", dat, 32'h000A000A);
    waitVld(40, n);
    checkOutput("const_period", n, 10);
    checkOutput("const_dat_second", dat, 32'h000A000A);
    checkOutput("const_ovr", {31'd0, ovr}, 32'd0);

    $display("[TB] latency of a single pulse");
    pdm_i = 4'b0000;
    waitVld(40, n);
    waitVld(40, n);
    checkOutput("lat_quiet_dat", dat, 32'h0);
    tick(7);
    pdm_i = 4'b0001;
    tick(1);
    pdm_i = 4'b0000;
    tick(1);
    checkOutput("lat_no_early_vld", {31'd0, vld}, 32'd0);
    tick(1);
    checkOutput("lat_vld", {31'd0, vld}, 32'd1);
    checkOutput("lat_dat", dat, 32'h00000001);
    waitVld(40, n);
    checkOutput("lat_next_period", n, 10);
    checkOutput("lat_next_dat", dat, 32'h0);

    $display("[TB] rng change mid-window");
    tick(4);
    rng = 8'd20;
    waitVld(40, n);
    checkOutput("chg_close_old_len", n, 6);
    checkOutput("chg_ovr_set", {31'd0, ovr}, 32'd1);
    waitVld(40, n);
    checkOutput("chg_new_period", n, 20);
    checkOutput("chg_ovr_sticky", {31'd0, ovr}, 32'd1);
    tick(5);
    rng = 8'd0;
    waitVld(40, n);
    checkOutput("chg_zero_last_window", n, 15);
    countVld(30, n);
    checkOutput("chg_zero_no_vld", n, 0);
    applyStimulus(1'b1, 8'd1, 4'b1010);
    tick(1);
    countVld(6, n);
    checkOutput("chg_rng1_vld_cont", n, 6);
    checkOutput("chg_rng1_dat_bits", dat, 32'h01000100);

    $display("[TB] abort and restart");
    ena = 1'b0;
    tick(2);
    checkOutput("abort_ovr_cleared", {31'd0, ovr}, 32'd0);
    applyStimulus(1'b1, 8'd10, 4'b0011);
    waitVld(40, n);
    checkOutput("abort_first_vld_latency", n, SYN + 11);
    checkOutput("abort_dat_before", dat, 32'h00000A0A);
    pdm_i = 4'b1111;
    tick(7);
    ena = 1'b0;
    countVld(12, n);
    checkOutput("abort_no_vld", n, 0);
    checkOutput("abort_dat_hold", dat, 32'h00000A0A);
    ena = 1'b1;
    waitVld(40, n);
    checkOutput("restart_vld_latency", n, SYN + 11);
    checkOutput("restart_dat", dat, 32'h0A0A0A0A);
    checkOutput("restart_ovr", {31'd0, ovr}, 32'd0);

    $display("[TB] async reset mid-run");
    tick(3);
    #2;
    rstn = 1'b0;
    ena  = 1'b0;
    #1;
    checkOutput("async_rst_dat", dat, 32'h0);
    checkOutput("async_rst_vld", {31'd0, vld}, 32'd0);
    checkOutput("async_rst_ovr", {31'd0, ovr}, 32'd0);
    tick(2);
    rstn = 1'b1;
    countVld(6, n);
    checkOutput("post_rst_idle_vld", n, 0);
    checkOutput("post_rst_idle_dat", dat, 32'h0);

    $display("[TB] loopback from PDM generator model");
    gcfg[0] = 255;
    gcfg[1] = 128;
    gcfg[2] = 1;
    gcfg[3] = 0;
    for (int c = 0; c < CHN; c++) gacc[c] = 0;
    applyStimulus(1'b1, 8'd255, 4'b0000);
    n = 0;
    for (int cyc = 0; cyc < 1400 && n < 4; cyc++) begin
      for (int c = 0; c < CHN; c++) begin
        gacc[c] = gacc[c] + gcfg[c];
        if (gacc[c] >= 255) begin
          gacc[c]  = gacc[c] - 255;
          pdm_i[c] = 1'b1;
        end else begin
          pdm_i[c] = 1'b0;
        end
      end
      tick(1);
      if (vld) begin
        n++;
        if (n >= 3) checkOutput($sformatf("loop_dat_win%0d", n), dat, 32'h000180FF);
      end
    end
    checkOutput("loop_window_count", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
